// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// State encoding, coin input indices and coin face values.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

  localparam int COIN_1_IDX  = 0;
  localparam int COIN_2_IDX  = 1;
  localparam int COIN_5_IDX  = 2;
  localparam int COIN_10_IDX = 3;

  localparam int COIN_1_VAL  = 1;
  localparam int COIN_2_VAL  = 2;
  localparam int COIN_5_VAL  = 5;
  localparam int COIN_10_VAL = 10;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector over a vector of debounced levels.
// Latency: combinational pulse in the cycle the level first reads high.
// Backpressure: none; a level held high yields exactly one pulse.
module edge_rise #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= lvl;
  end

  assign rise = lvl & ~prev;

endmodule

// File: rtl/vend_ctrl_core.sv
// Vending control core: coin credit, product vend, change/refund return.
// Latency: outputs update one cycle after an input edge is seen.
// Backpressure: none; edges arriving while busy are rejected or dropped.
module vend_ctrl_core
  import vend_pkg::*;
#(
  parameter int                            NUM_PROD    = 4,
  parameter int                            CREDIT_W    = 8,
  parameter int                            MAX_CREDIT  = 99,
  parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICE_LIST  = {8'd10, 8'd7, 8'd5, 8'd3},
  parameter int                            HOLD_CYC    = 4,
  parameter bit                            KEEP_CREDIT = 1'b0
) (
  input  logic                                          clk_brd,
  input  logic                                          reset_brd,
  input  logic [3:0]                                    coin_in,
  input  logic [NUM_PROD-1:0]                           sel_in,
  input  logic                                          cancel_in,
  output logic                                          power,
  output logic                                          used,
  output logic                                          get,
  output logic                                          back,
  output logic [CREDIT_W-1:0]                           credit,
  output logic [CREDIT_W-1:0]                           change,
  output logic [((NUM_PROD > 1) ? $clog2(NUM_PROD) : 1)-1:0] prod_id,
  output logic                                          coin_rej,
  output logic                                          deny
);

  localparam int PID_W  = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [HOLD_W-1:0]   HOLD_LD = HOLD_W'(HOLD_CYC);
  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

  logic [NUM_PROD+4:0] lvl_all, rise_all;
  logic [3:0]          coin_e;
  logic [NUM_PROD-1:0] sel_e;
  logic                cancel_e;

  assign lvl_all  = {cancel_in, sel_in, coin_in};
  assign coin_e   = rise_all[3:0];
  assign sel_e    = rise_all[4 +: NUM_PROD];
  assign cancel_e = rise_all[NUM_PROD+4];

  edge_rise #(.W(NUM_PROD + 5)) u_edge (
    .clk   (clk_brd),
    .rst_n (reset_brd),
    .lvl   (lvl_all),
    .rise  (rise_all)
  );

  state_t              state_q, state_nx;
  logic [CREDIT_W-1:0] credit_q, credit_nx;
  logic [HOLD_W-1:0]   cnt_q, cnt_nx;
  logic [PID_W-1:0]    prod_q, prod_nx;
  logic                rej_q, rej_nx;
  logic                deny_q, deny_nx;
  logic                power_q;

  // Lowest-index select edge wins; its price is looked up alongside.
  logic                sel_any;
  logic [PID_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] price;

  always_comb begin
    sel_idx = '0;
    price   = '0;
    for (int i = NUM_PROD - 1; i >= 0; i--) begin
      if (sel_e[i]) begin
        sel_idx = PID_W'(i);
        price   = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign sel_any = |sel_e;

  // Only the highest-value coin edge in a cycle is considered.
  logic [CREDIT_W:0] coin_val;
  logic [3:0]        coin_top;
  logic              coin_extra;
  logic [CREDIT_W:0] coin_sum;

  always_comb begin
    coin_val = '0;
    coin_top = '0;
    if (coin_e[COIN_10_IDX]) begin
      coin_val = (CREDIT_W+1)'(COIN_10_VAL);
      coin_top[COIN_10_IDX] = 1'b1;
    end else if (coin_e[COIN_5_IDX]) begin
      coin_val = (CREDIT_W+1)'(COIN_5_VAL);
      coin_top[COIN_5_IDX] = 1'b1;
    end else if (coin_e[COIN_2_IDX]) begin
      coin_val = (CREDIT_W+1)'(COIN_2_VAL);
      coin_top[COIN_2_IDX] = 1'b1;
    end else if (coin_e[COIN_1_IDX]) begin
      coin_val = (CREDIT_W+1)'(COIN_1_VAL);
      coin_top[COIN_1_IDX] = 1'b1;
    end
  end

  assign coin_extra = |(coin_e & ~coin_top);
  assign coin_sum   = {1'b0, credit_q} + coin_val;

  always_comb begin
    state_nx  = state_q;
    credit_nx = credit_q;
    cnt_nx    = cnt_q;
    prod_nx   = prod_q;
    rej_nx    = 1'b0;
    deny_nx   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (cancel_e) begin
          rej_nx = |coin_e;
          if (credit_q != '0) begin
            state_nx = ST_REFUND;
            cnt_nx   = HOLD_LD;
          end
        end else if (sel_any) begin
          rej_nx = |coin_e;
          if (credit_q >= price) begin
            state_nx  = ST_VEND;
            credit_nx = credit_q - price;
            prod_nx   = sel_idx;
            cnt_nx    = HOLD_LD;
          end else begin
            deny_nx = 1'b1;
          end
        end else if (|coin_e) begin
          if (coin_sum > MAX_C) begin
            rej_nx = 1'b1;
          end else begin
            rej_nx    = coin_extra;
            credit_nx = coin_sum[CREDIT_W-1:0];
            state_nx  = ST_CREDIT;
          end
        end
      end
      ST_VEND: begin
        rej_nx = |coin_e;
        if (cnt_q <= HOLD_W'(1)) begin
          if (credit_q == '0) begin
            state_nx = ST_IDLE;
          end else if (KEEP_CREDIT) begin
            state_nx = ST_CREDIT;
          end else begin
            state_nx = ST_REFUND;
            cnt_nx   = HOLD_LD;
          end
        end else begin
          cnt_nx = cnt_q - HOLD_W'(1);
        end
      end
      ST_REFUND: begin
        rej_nx = |coin_e;
        if (cnt_q <= HOLD_W'(1)) begin
          state_nx  = ST_IDLE;
          credit_nx = '0;
        end else begin
          cnt_nx = cnt_q - HOLD_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_brd or negedge reset_brd) begin
    if (!reset_brd) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rej_q    <= 1'b0;
      deny_q   <= 1'b0;
      power_q  <= 1'b0;
    end else begin
      state_q  <= state_nx;
      credit_q <= credit_nx;
      cnt_q    <= cnt_nx;
      prod_q   <= prod_nx;
      rej_q    <= rej_nx;
      deny_q   <= deny_nx;
      power_q  <= 1'b1;
    end
  end

  assign power    = power_q;
  assign used     = (state_q != ST_IDLE);
  assign get      = (state_q == ST_VEND);
  assign back     = (state_q == ST_REFUND);
  assign credit   = credit_q;
  assign change   = back ? credit_q : '0;
  assign prod_id  = get ? prod_q : '0;
  assign coin_rej = rej_q;
  assign deny     = deny_q;

endmodule

// File: tb/tb_vend_ctrl_core.sv
// Scoreboarded bench for vend_ctrl_core: expected output bursts are queued
// at stimulus time and matched against bursts collected by a monitor.
module tb_vend_ctrl_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] coin_in = '0, sel_in = '0;
  logic       cancel_in = 1'b0;
  logic       power, used, get, back, coin_rej, deny;
  logic [7:0] credit, change;
  logic [1:0] prod_id;

  logic [3:0] coin_k = '0, sel_k = '0;
  logic       cancel_k = 1'b0;
  logic       power_k, used_k, get_k, back_k, coin_rej_k, deny_k;
  logic [7:0] credit_k, change_k;
  logic [1:0] prod_id_k;

  vend_ctrl_core #(
    .NUM_PROD(4), .CREDIT_W(8), .MAX_CREDIT(99),
    .PRICE_LIST({8'd10, 8'd7, 8'd5, 8'd3}), .HOLD_CYC(4), .KEEP_CREDIT(1'b0)
  ) u_dut (
    .clk_brd(clk), .reset_brd(rst_n), .coin_in(coin_in), .sel_in(sel_in),
    .cancel_in(cancel_in), .power(power), .used(used), .get(get), .back(back),
    .credit(credit), .change(change), .prod_id(prod_id), .coin_rej(coin_rej),
    .deny(deny)
  );

  vend_ctrl_core #(
    .NUM_PROD(4), .CREDIT_W(8), .MAX_CREDIT(99),
    .PRICE_LIST({8'd10, 8'd7, 8'd5, 8'd3}), .HOLD_CYC(4), .KEEP_CREDIT(1'b1)
  ) u_keep (
    .clk_brd(clk), .reset_brd(rst_n), .coin_in(coin_k), .sel_in(sel_k),
    .cancel_in(cancel_k), .power(power_k), .used(used_k), .get(get_k), .back(back_k),
    .credit(credit_k), .change(change_k), .prod_id(prod_id_k), .coin_rej(coin_rej_k),
    .deny(deny_k)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  localparam int EV_GET = 0, EV_BACK = 1, EV_DENY = 2, EV_REJ = 3;
  typedef struct { int kind; int val; int len; } ev_t;
  ev_t exp_q[$];

  task automatic expect_ev(input int kind, input int val, input int len);
    ev_t e;
    e.kind = kind; e.val = val; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int val, input int len);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_val", val, e.val);
      chk("ev_len", len, e.len);
    end
  endtask

  // Burst monitor: value is taken on the first active cycle, event closes on the fall.
  int         mlen[4];
  int         mval[4];
  int         mcur[4];
  logic [3:0] msig;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mlen[i] = 0;
    end else begin
      msig    = {coin_rej, deny, back, get};
      mcur[0] = int'(prod_id);
      mcur[1] = int'(change);
      mcur[2] = int'(credit);
      mcur[3] = int'(credit);
      for (int i = 0; i < 4; i++) begin
        if (msig[i]) begin
          if (mlen[i] == 0) mval[i] = mcur[i];
          mlen[i]++;
        end else if (mlen[i] > 0) begin
          got_ev(i, mval[i], mlen[i]);
          mlen[i] = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] s, input logic x);
    coin_in = c; sel_in = s; cancel_in = x;
    tick(1);
    coin_in = '0; sel_in = '0; cancel_in = 1'b0;
    tick(1);
  endtask

  int gets, backs;

  initial begin
    tick(2);
    chk("rst_power", power, 0);
    chk("rst_credit", credit, 0);
    chk("rst_used", used, 0);
    chk("rst_get", get, 0);
    chk("rst_back", back, 0);
    chk("rst_rej", coin_rej, 0);
    rst_n = 1'b1;
    chk("power_pre_edge", power, 0);
    tick(1);
    chk("power_up", power, 1);

    // coins 1,2,5 then product 1 (price 5): change 3
    drive(4'b0001, 4'b0000, 1'b0); chk("credit_1", credit, 1); chk("used_credit", used, 1);
    drive(4'b0010, 4'b0000, 1'b0); chk("credit_3", credit, 3);
    drive(4'b0100, 4'b0000, 1'b0); chk("credit_8", credit, 8);
    expect_ev(EV_GET, 1, 4);
    expect_ev(EV_BACK, 3, 4);
    drive(4'b0000, 4'b0010, 1'b0);
    chk("vend_credit", credit, 3);
    tick(12);
    chk("after_vend_credit", credit, 0);
    chk("after_vend_used", used, 0);
    chk("q_empty_vend", exp_q.size(), 0);

    // insufficient credit for product 3
    drive(4'b0001, 4'b0000, 1'b0);
    drive(4'b0010, 4'b0000, 1'b0);
    expect_ev(EV_DENY, 3, 1);
    drive(4'b0000, 4'b1000, 1'b0);
    chk("deny_credit", credit, 3);
    chk("deny_get", get, 0);
    chk("deny_used", used, 1);
    tick(2);
    chk("q_empty_deny", exp_q.size(), 0);
    expect_ev(EV_BACK, 3, 4);
    drive(4'b0000, 4'b0000, 1'b1);
    tick(8);
    chk("cancel_credit", credit, 0);

    // credit cap
    repeat (9) drive(4'b1000, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    chk("credit_95", credit, 95);
    expect_ev(EV_REJ, 95, 1);
    drive(4'b1000, 4'b0000, 1'b0);
    chk("cap_kept", credit, 95);
    drive(4'b0010, 4'b0000, 1'b0);
    chk("credit_97", credit, 97);
    tick(1);
    chk("q_empty_cap", exp_q.size(), 0);
    expect_ev(EV_BACK, 97, 4);
    drive(4'b0000, 4'b0000, 1'b1);
    tick(8);

    // simultaneous 5 and 2: only 5 accepted
    expect_ev(EV_REJ, 5, 1);
    drive(4'b0110, 4'b0000, 1'b0);
    chk("multi_coin_credit", credit, 5);
    expect_ev(EV_BACK, 5, 4);
    drive(4'b0000, 4'b0000, 1'b1);
    tick(8);
    chk("q_empty_multi", exp_q.size(), 0);

    // cancel beats select
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0001, 4'b0000, 1'b0);
    drive(4'b0010, 4'b0000, 1'b0);
    expect_ev(EV_BACK, 8, 4);
    drive(4'b0000, 4'b0001, 1'b1);
    chk("cxl_back", back, 1);
    chk("cxl_change", change, 8);
    chk("cxl_get", get, 0);
    tick(8);
    chk("cxl_credit", credit, 0);
    chk("q_empty_cxl", exp_q.size(), 0);

    // keep-credit instance: vend product 0 (price 3) from 10
    coin_k = 4'b1000; tick(1); coin_k = '0; tick(1);
    chk("keep_credit_10", credit_k, 10);
    gets = 0; backs = 0;
    sel_k = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      sel_k = '0;
      gets  += int'(get_k);
      backs += int'(back_k);
    end
    chk("keep_get_cycles", gets, 4);
    chk("keep_back_cycles", backs, 0);
    chk("keep_credit_7", credit_k, 7);
    chk("keep_used", used_k, 1);

    // a held level counts once
    coin_in = 4'b0001; tick(3); coin_in = '0; tick(1);
    chk("held_coin_once", credit, 1);
    expect_ev(EV_BACK, 1, 4);
    drive(4'b0000, 4'b0000, 1'b1);
    tick(8);

    // reset in the middle of a vend
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0010, 1'b0);
    chk("mid_get", get, 1);
    chk("mid_prod", prod_id, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_get", get, 0);
    chk("mrst_credit", credit, 0);
    chk("mrst_used", used, 0);
    chk("mrst_power", power, 0);
    tick(2);
    rst_n = 1'b1;
    chk("mrst_power_hold", power, 0);
    tick(1);
    chk("mrst_power_up", power, 1);
    chk("mrst_used_after", used, 0);

    tick(4);
    chk("q_empty_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
